// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared MSDAP states, phases and default sizes
package msdap_pkg;

    localparam int DEF_WORD_W      = 16;
    localparam int DEF_RJ_COUNT    = 16;
    localparam int DEF_COEFF_COUNT = 512;
    localparam int DEF_SLEEP_ZEROS = 800;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RJ,
        ST_RJ,
        ST_COEFF,
        ST_DATA,
        ST_SLEEP
    } state_e;

    localparam logic [1:0] PHASE_RJ    = 2'd0;
    localparam logic [1:0] PHASE_COEFF = 2'd1;
    localparam logic [1:0] PHASE_DATA  = 2'd2;
    localparam logic [1:0] PHASE_NONE  = 2'd3;

    // SLEEP is still the data phase: words keep streaming, only dataValid is gated.
    function automatic logic [1:0] state_phase(input state_e s);
        case (s)
            ST_RJ:             return PHASE_RJ;
            ST_COEFF:          return PHASE_COEFF;
            ST_DATA, ST_SLEEP: return PHASE_DATA;
            default:           return PHASE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/msdap_edge_sync.sv
// rtl/msdap_edge_sync.sv - dClk synchroniser, rising-edge strobe and matched frame/data delay
module msdap_edge_sync #(
    parameter int CHANNELS = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                dclk_i,
    input  logic                frame_i,
    input  logic [CHANNELS-1:0] data_i,
    output logic                strobe_o,
    output logic                frame_o,
    output logic [CHANNELS-1:0] data_o
);

    logic [2:0]                dclk_q;
    logic [1:0]                frame_q;
    logic [1:0][CHANNELS-1:0]  data_q;
    logic                      strobe_q;
    logic                      frame_out_q;
    logic [CHANNELS-1:0]       data_out_q;

    // frame/data take the same two sync stages as dClk so they line up with the strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dclk_q      <= '0;
            frame_q     <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            frame_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            dclk_q      <= {dclk_q[1:0], dclk_i};
            frame_q     <= {frame_q[0], frame_i};
            data_q      <= {data_q[0], data_i};
            strobe_q    <= dclk_q[1] & ~dclk_q[2];
            frame_out_q <= frame_q[1];
            data_out_q  <= data_q[1];
        end
    end

    assign strobe_o = strobe_q;
    assign frame_o  = frame_out_q;
    assign data_o   = data_out_q;

endmodule

// File: rtl/msdap_frame_rx.sv
// rtl/msdap_frame_rx.sv - MSDAP serial frame receiver: Rj/coeff/data classification and sleep detect
module msdap_frame_rx
    import msdap_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int CHANNELS    = 2,
    parameter int RJ_COUNT    = DEF_RJ_COUNT,
    parameter int COEFF_COUNT = DEF_COEFF_COUNT,
    parameter int SLEEP_ZEROS = DEF_SLEEP_ZEROS
) (
    input  logic                               sClk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               flush,
    input  logic                               dClk,
    input  logic                               frame,
    input  logic [CHANNELS-1:0]                inData,
    output logic                               inReady,
    output logic                               rjValid,
    output logic                               coeffValid,
    output logic                               dataValid,
    output logic [CHANNELS*WORD_W-1:0]         wordOut,
    output logic [$clog2(COEFF_COUNT)-1:0]     wordIndex,
    output logic                               sleep,
    output logic                               frameErr
);

    localparam int IDX_W = $clog2(COEFF_COUNT);
    localparam int ZC_W  = $clog2(SLEEP_ZEROS + 1);
    localparam int BC_W  = $clog2(WORD_W);
    localparam logic [BC_W-1:0]  BIT_MSB  = BC_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] RJ_LAST  = IDX_W'(RJ_COUNT - 1);
    localparam logic [IDX_W-1:0] CO_LAST  = IDX_W'(COEFF_COUNT - 1);
    localparam logic [ZC_W-1:0]  ZC_LAST  = ZC_W'(SLEEP_ZEROS - 1);

    logic                s_strobe;
    logic                s_frame;
    logic [CHANNELS-1:0] s_data;

    msdap_edge_sync #(.CHANNELS(CHANNELS)) u_sync (
        .clk_i    (sClk),
        .reset_i  (reset),
        .dclk_i   (dClk),
        .frame_i  (frame),
        .data_i   (inData),
        .strobe_o (s_strobe),
        .frame_o  (s_frame),
        .data_o   (s_data)
    );

    state_e                             state_q, state_d;
    logic [BC_W-1:0]                    bitcnt_q, bitcnt_d;
    logic [CHANNELS-1:0][WORD_W-2:0]    shreg_q, shreg_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [ZC_W-1:0]                    zcnt_q, zcnt_d;
    logic                               need_frame_q, need_frame_d;
    logic [CHANNELS*WORD_W-1:0]         word_q, word_d;
    logic [IDX_W-1:0]                   windex_q, windex_d;
    logic                               sleep_q, sleep_d;
    logic                               rj_v_q, rj_v_d, co_v_q, co_v_d, da_v_q, da_v_d;
    logic                               ferr_q, ferr_d;
    logic [CHANNELS-1:0][WORD_W-1:0]    next_word;
    logic                               all_zero;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        zcnt_d       = zcnt_q;
        need_frame_d = need_frame_q;
        word_d       = word_q;
        windex_d     = windex_q;
        sleep_d      = sleep_q;
        rj_v_d       = 1'b0;
        co_v_d       = 1'b0;
        da_v_d       = 1'b0;
        ferr_d       = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            next_word[c] = {shreg_q[c], s_data[c]};
        end
        all_zero = (next_word == '0);

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT_RJ;
            end
            ST_WAIT_RJ: begin
                if (s_strobe && s_frame) begin
                    for (int c = 0; c < CHANNELS; c++) shreg_d[c] = next_word[c][WORD_W-2:0];
                    bitcnt_d = BIT_MSB - 1'b1;
                    idx_d    = '0;
                    state_d  = ST_RJ;
                end
            end
            default: begin
                if (flush && state_phase(state_q) == PHASE_DATA) begin
                    state_d      = ST_DATA;
                    bitcnt_d     = BIT_MSB;
                    zcnt_d       = '0;
                    idx_d        = '0;
                    sleep_d      = 1'b0;
                    need_frame_d = 1'b1;
                end else if (s_strobe && (s_frame || !need_frame_q)) begin
                    need_frame_d = 1'b0;
                    for (int c = 0; c < CHANNELS; c++) shreg_d[c] = next_word[c][WORD_W-2:0];
                    if (s_frame && bitcnt_q != BIT_MSB) begin
                        // Misframed bit restarts the word as its MSB.
                        ferr_d   = 1'b1;
                        bitcnt_d = BIT_MSB - 1'b1;
                    end else if (bitcnt_q != '0) begin
                        bitcnt_d = bitcnt_q - 1'b1;
                    end else begin
                        bitcnt_d = BIT_MSB;
                        word_d   = next_word;
                        windex_d = idx_q;
                        idx_d    = idx_q + 1'b1;
                        case (state_phase(state_q))
                            PHASE_RJ: begin
                                rj_v_d = 1'b1;
                                if (idx_q == RJ_LAST) begin
                                    state_d = ST_COEFF;
                                    idx_d   = '0;
                                end
                            end
                            PHASE_COEFF: begin
                                co_v_d = 1'b1;
                                if (idx_q == CO_LAST) begin
                                    state_d = ST_DATA;
                                    idx_d   = '0;
                                end
                            end
                            default: begin
                                if (!all_zero) begin
                                    zcnt_d  = '0;
                                    da_v_d  = 1'b1;
                                    sleep_d = 1'b0;
                                    state_d = ST_DATA;
                                end else if (state_q == ST_DATA) begin
                                    da_v_d = 1'b1;
                                    zcnt_d = zcnt_q + 1'b1;
                                    if (zcnt_q == ZC_LAST) begin
                                        state_d = ST_SLEEP;
                                        sleep_d = 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sClk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= BIT_MSB;
            shreg_q      <= '0;
            idx_q        <= '0;
            zcnt_q       <= '0;
            need_frame_q <= 1'b0;
            word_q       <= '0;
            windex_q     <= '0;
            sleep_q      <= 1'b0;
            rj_v_q       <= 1'b0;
            co_v_q       <= 1'b0;
            da_v_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            zcnt_q       <= zcnt_d;
            need_frame_q <= need_frame_d;
            word_q       <= word_d;
            windex_q     <= windex_d;
            sleep_q      <= sleep_d;
            rj_v_q       <= rj_v_d;
            co_v_q       <= co_v_d;
            da_v_q       <= da_v_d;
            ferr_q       <= ferr_d;
        end
    end

    assign inReady    = (state_q != ST_IDLE);
    assign rjValid    = rj_v_q;
    assign coeffValid = co_v_q;
    assign dataValid  = da_v_q;
    assign wordOut    = word_q;
    assign wordIndex  = windex_q;
    assign sleep      = sleep_q;
    assign frameErr   = ferr_q;

endmodule
